// File: rtl/seg7_encoder.sv
// Recovers a hex digit from a debounced active-low 7-segment pattern and delivers it over a valid/ready handshake.
// Optional build macro SEG7_ENCODER_ERRCNT_EN adds a saturating 8-bit err_cnt output.
//
// state | meaning
// IDLE  | no pattern sampled since reset
// COUNT | counting consecutive identical samples of pat
// LOCK  | pat is stable and classified; repeats are ignored
module seg7_encoder #(
  parameter int STABLE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic [3:0] hex,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
`ifdef SEG7_ENCODER_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       overrun
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_N);
  localparam logic [6:0] BLANK      = 7'h7F;

  typedef enum logic [1:0] {IDLE, COUNT, LOCK} state_t;

  state_t     state, state_nxt;
  logic [6:0] pat, pat_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] hex_nxt;
  logic       out_valid_nxt, err_nxt, overrun_nxt;
  logic       fire, legal;
  logic [3:0] digit;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = {1'b1, 4'h0};
      7'h79: decode = {1'b1, 4'h1};
      7'h24: decode = {1'b1, 4'h2};
      7'h30: decode = {1'b1, 4'h3};
      7'h19: decode = {1'b1, 4'h4};
      7'h12: decode = {1'b1, 4'h5};
      7'h02: decode = {1'b1, 4'h6};
      7'h78: decode = {1'b1, 4'h7};
      7'h00: decode = {1'b1, 4'h8};
      7'h10: decode = {1'b1, 4'h9};
      7'h08: decode = {1'b1, 4'hA};
      7'h03: decode = {1'b1, 4'hB};
      7'h46: decode = {1'b1, 4'hC};
      7'h21: decode = {1'b1, 4'hD};
      7'h06: decode = {1'b1, 4'hE};
      7'h0E: decode = {1'b1, 4'hF};
      default: decode = 5'b0;
    endcase
  endfunction

  assign {legal, digit} = decode(pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    if (seg_valid) begin
      case (state)
        IDLE: begin
          pat_nxt   = seg_in;
          cnt_nxt   = 4'd1;
          state_nxt = COUNT;
        end
        COUNT: begin
          if (seg_in == pat) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt_nxt == STABLE_CNT) begin
              fire      = 1'b1;
              state_nxt = LOCK;
            end
          end else begin
            pat_nxt = seg_in;
            cnt_nxt = 4'd1;
          end
        end
        LOCK: begin
          if (seg_in != pat) begin
            pat_nxt   = seg_in;
            cnt_nxt   = 4'd1;
            state_nxt = COUNT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A new digit may replace the pending one only if the consumer takes the old one on this edge.
  always_comb begin
    hex_nxt       = hex;
    out_valid_nxt = out_valid;
    overrun_nxt   = overrun;
    err_nxt       = fire && !legal && (pat != BLANK);
    if (out_valid && out_ready) out_valid_nxt = 1'b0;
    if (fire && legal) begin
      if (!out_valid || out_ready) begin
        hex_nxt       = digit;
        out_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat       <= BLANK;
      cnt       <= 4'd0;
      hex       <= 4'h0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pat       <= pat_nxt;
      cnt       <= cnt_nxt;
      hex       <= hex_nxt;
      out_valid <= out_valid_nxt;
      err       <= err_nxt;
      overrun   <= overrun_nxt;
    end
  end

`ifdef SEG7_ENCODER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             err_cnt <= 8'd0;
    else if (err_nxt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg7_encoder.sv
// Directed self-checking bench for seg7_encoder with STABLE_N=4.
module tb_seg7_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       seg_valid = 1'b0;
  logic [3:0] hex;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err;
  logic       overrun;
`ifdef SEG7_ENCODER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  seg7_encoder #(.STABLE_N(4)) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .seg_valid(seg_valid),
    .hex(hex),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err(err),
`ifdef SEG7_ENCODER_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [6:0] p, input logic v);
    seg_in    = p;
    seg_valid = v;
    step();
  endtask

  task automatic smp_n(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) smp(p, 1'b1);
  endtask

  task automatic consume();
    seg_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Reset is asserted between edges so the checks see its asynchronous effect.
  task automatic do_reset(input string tag);
    seg_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_valid"}, out_valid, 0);
    chk({tag, "_rst_hex"}, hex, 0);
    chk({tag, "_rst_ovr"}, overrun, 0);
    chk({tag, "_rst_err"}, err, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    chk("init_hex", hex, 0);
    chk("init_valid", out_valid, 0);
    chk("init_err", err, 0);
    chk("init_ovr", overrun, 0);
    step();
    rst = 1'b0;

    // digit 2 after four samples, then no re-emission
    for (int i = 1; i <= 3; i++) begin
      smp(7'h24, 1'b1);
      chk("d2_early", out_valid, 0);
    end
    smp(7'h24, 1'b1);
    chk("d2_valid", out_valid, 1);
    chk("d2_hex", hex, 4'h2);
    consume();
    chk("d2_consumed", out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      smp(7'h24, 1'b1);
      chk("d2_no_repeat", out_valid, 0);
    end
    chk("d2_ovr", overrun, 0);

    // interrupted run: 24,24,24 then 30 x4
    do_reset("d3");
    smp_n(7'h24, 3);
    chk("d3_no_2", out_valid, 0);
    smp_n(7'h30, 3);
    chk("d3_early", out_valid, 0);
    smp(7'h30, 1'b1);
    chk("d3_valid", out_valid, 1);
    chk("d3_hex", hex, 4'h3);
    consume();

    // illegal pattern pulses err once
    smp_n(7'h55, 3);
    chk("ill_early", err, 0);
    smp(7'h55, 1'b1);
    chk("ill_err", err, 1);
    chk("ill_valid", out_valid, 0);
    smp(7'h55, 1'b1);
    chk("ill_err_pulse", err, 0);
`ifdef SEG7_ENCODER_ERRCNT_EN
    chk("ill_err_cnt", err_cnt, 1);
`endif

    // blank is silent
    smp_n(7'h7F, 4);
    chk("blank_err", err, 0);
    chk("blank_valid", out_valid, 0);
    smp(7'h7F, 1'b0);
    chk("blank_err2", err, 0);

    // overrun: 1 pending, 8 arrives with out_ready low
    do_reset("ov");
    smp_n(7'h79, 4);
    chk("ov_d1", hex, 4'h1);
    smp_n(7'h00, 4);
    chk("ov_hex_kept", hex, 4'h1);
    chk("ov_flag", overrun, 1);
    chk("ov_valid", out_valid, 1);
    smp(7'h00, 1'b0);
    chk("ov_sticky", overrun, 1);

    // same case, old digit consumed on the acceptance edge
    do_reset("ovr");
    smp_n(7'h79, 4);
    smp_n(7'h00, 3);
    out_ready = 1'b1;
    smp(7'h00, 1'b1);
    out_ready = 1'b0;
    chk("ovr_hex", hex, 4'h8);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_flag", overrun, 0);
    seg_valid = 1'b0;

    // gaps in seg_valid do not break stability
    do_reset("gap");
    for (int i = 0; i < 6; i++) smp(7'h06, (i % 2) == 0);
    chk("gap_early", out_valid, 0);
    smp(7'h06, 1'b1);
    chk("gap_valid", out_valid, 1);
    chk("gap_hex", hex, 4'hE);
    consume();

    // reset after the third sample restarts the count
    do_reset("gr");
    for (int i = 0; i < 5; i++) smp(7'h06, (i % 2) == 0);
    do_reset("gr2");
    for (int i = 0; i < 5; i++) smp(7'h06, (i % 2) == 0);
    chk("gr_no_out", out_valid, 0);
    smp(7'h06, 1'b0);
    smp(7'h06, 1'b1);
    chk("gr_fresh", out_valid, 1);
    chk("gr_hex", hex, 4'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_encoder.md
SEG7_ENCODER -- requirements
Module: seg7_encoder

Interface
REQ-001 Parameter STABLE_N, default 4, legal range 2..15; number of consecutive identical sampled patterns required before a pattern is accepted.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 seg_in  input  7  sampled segment pattern, active-low; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 seg_valid  input  1  qualifies seg_in as a sample in the current cycle.
REQ-006 hex  output  4  recovered hex digit.
REQ-007 out_valid  output  1  hex holds an undelivered digit.
REQ-008 out_ready  input  1  consumer accepts hex when asserted together with out_valid.
REQ-009 err  output  1  one-cycle pulse when an illegal pattern becomes stable.
REQ-010 overrun  output  1  sticky flag; a digit was accepted while out_valid was high and not accepted.

Function
REQ-011 The legal table, as gfedcba hex, SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-012 Pattern 7F (blank) SHALL be treated as legal-no-digit: it produces no output and no err.
REQ-013 Any other pattern SHALL be treated as illegal.
REQ-014 The FSM SHALL have states IDLE, COUNT and LOCK, plus a registered last pattern and a 4-bit counter cnt.
REQ-015 IDLE: when seg_valid=1, the block SHALL store seg_in, set cnt=1 and move to COUNT.
REQ-016 COUNT: when seg_valid=1 with the same pattern, cnt SHALL increment; on reaching STABLE_N the pattern is classified (REQ-018) and the FSM moves to LOCK.
REQ-017 COUNT: when seg_valid=1 with a different pattern, the block SHALL store it, set cnt=1 and stay in COUNT.
REQ-018 Classification SHALL work as follows:
- legal digit: load hex and set out_valid on the edge of the STABLE_N-th sample, so out_valid is visible the cycle after that sample;
- illegal pattern: pulse err for exactly one cycle;
- blank: no action.
REQ-019 LOCK: the same pattern SHALL be ignored, so there is no re-emission; a different valid sample SHALL store the new pattern, set cnt=1 and move to COUNT.
REQ-020 Cycles with seg_valid=0 SHALL hold state, cnt and pattern unchanged; gaps do not break stability.
REQ-021 Output handshake:
- out_valid clears on the edge where out_valid and out_ready are both 1;
- hex SHALL remain stable while out_valid=1.
REQ-022 If a legal digit is accepted while out_valid=1 and out_ready=0, the new digit SHALL be dropped, hex kept, and overrun set.
REQ-023 If a digit is accepted in the same cycle that the old one is consumed (out_ready=1), the new digit SHALL load and out_valid SHALL stay 1 with no overrun.
REQ-024 overrun SHALL clear only on reset.

Reset
REQ-025 On rst=1, immediately and independent of clk: state=IDLE, cnt=0, stored pattern=7F, hex=0, out_valid=0, err=0, overrun=0.
REQ-026 Reset mid-COUNT or with out_valid=1 SHALL discard partial and pending digits; the first sample after release starts a fresh count.

Configuration
REQ-027 Macro SEG7_ENCODER_ERRCNT_EN:
- when defined, adds output err_cnt, 8 bits, which counts err pulses, saturates at 255 and resets to 0;
- when undefined, err_cnt is absent and err behaviour is unchanged.

Verification
REQ-028 STABLE_N=4, seg_valid=1, seg_in=24 for 4 cycles -> out_valid rises the cycle after the 4th sample, hex=2; holding 24 a further 10 cycles produces no second digit.
REQ-029 Samples 24,24,24,30,30,30,30 -> a single digit, hex=3; no digit 2 is emitted.
REQ-030 seg_in=55 stable for 4 samples -> err high exactly 1 cycle, out_valid stays 0; with SEG7_ENCODER_ERRCNT_EN defined, err_cnt=1.
REQ-031 Digit 1 (79) pending with out_ready=0, then digit 8 (00) stable -> hex stays 1, overrun=1; repeat the same case with out_ready=1 on the acceptance cycle -> hex=8, overrun=0.
REQ-032 seg_in=06 with seg_valid toggling 1,0,1,0,1,0,1 -> hex=E after the 4th valid sample; rst pulsed after the 3rd sample -> no output.
